ind_serializer: RTL and testbench
=================================

# ind_serializer

Indication-path serializer that sits directly upstream of the portal's user `read` port. It accepts one whole indication message per handshake: a method id, a word count and up to MAX_WORDS payload words. It then emits the message as a sequence of 32-bit beats with a remaining-length tag, which is exactly what the portal's single-word holding register and interrupt logic consume. The first beat is a header, followed by one beat per payload word, and an optional checksum trailer.

## Interface
Parameters:
- MAX_WORDS, default 4: payload capacity in 32-bit words (1..15).
- METHOD_W, default 16: method id width (≤16).

Ports:
- CLK  in  1: sole clock.
- nRST  in  1: reset, asynchronous assert, active-low.
- in$enq__ENA  in  1: message valid. A message transfers when ENA & RDY.
- in$enq$method  in  METHOD_W: indication method id.
- in$enq$count  in  16: payload word count.
- in$enq$data  in  32*MAX_WORDS: payload; word i is at bits [32i+31:32i].
- in$enq__RDY  out  1: serializer idle and able to accept a message.
- out$enq__ENA  out  1: beat valid, toward the portal `read$enq`.
- out$enq$v  out  32: beat data.
- out$enq$length  out  16: beats remaining including this one; never 0 while ENA.
- out$enq__RDY  in  1: portal holding register empty. A beat transfers when ENA & RDY.
- overflow  out  1: sticky; set when an input count exceeded MAX_WORDS.

## Operation
- Three states:
  - IDLE: in$enq__RDY=1, out$enq__ENA=0.
  - HDR: ENA=1, header beat.
  - PAY: ENA=1, payload or trailer beat.
- Transitions:
  - IDLE→HDR on in ENA&RDY. The block latches method, count and data.
  - The latched count is eff = min(count, MAX_WORDS). If count > MAX_WORDS, overflow is set and excess words are dropped.
  - HDR→PAY on out transfer when total > 1, otherwise HDR→IDLE.
  - PAY steps an index on each out transfer, and goes to IDLE after the beat with length 1.
- Beat count: total = eff + 1 (+1 with checksum).
- Header beat: v = {zero-extended method[15:0], eff[15:0]}, length = total.
- Payload beat k (k = 0..eff-1): v = data word k, length = total − 1 − k.
- The output of a beat is held stable while ENA & !RDY. ENA never depends combinationally on RDY.
- count = 0: header only, length 1, back to IDLE.
- in$enq__RDY is asserted only in IDLE. There is no bypass, so a new message is accepted no earlier than the cycle after the final beat transfers.
- overflow clears only on reset.

## Timing
- Message accepted at edge T gives header ENA at T+1.
- With RDY held high, one beat transfers per cycle. A message with N words occupies N+2 cycles from acceptance to the next in$enq__RDY.
- Backpressure: each cycle with RDY=0 stalls the FSM and holds all outputs unchanged.
- Reset values: in$enq__RDY=1; out$enq__ENA=0; out$enq$v=0; out$enq$length=0; overflow=0; state IDLE; index 0.
- nRST asserted mid-message:
  - ENA drops asynchronously and the message is discarded.
  - After release, the block is IDLE on the first edge.
- Length arithmetic is 16-bit unsigned. Its maximum value is MAX_WORDS+2, so it cannot wrap.

## Configuration
- IND_SER_CHECKSUM_EN defined:
  - One trailer beat is appended after the payload. Its v is the XOR of the header v and all emitted payload words, and its length is 1.
  - total and all length tags include the trailer.
- IND_SER_CHECKSUM_EN undefined: no trailer, and the final payload beat (or the header, when eff=0) carries length 1.

## Structure
- Package ind_ser_pkg holds:
  - the state enum (IDLE/HDR/PAY);
  - a header-pack function (method, eff) → 32-bit word;
  - the length width constant (16).
- Single module. The payload store is a MAX_WORDS×32 register array indexed by a $clog2(MAX_WORDS+1)-bit counter, and needs no sub-module.

## Test plan
- method=0x0005, count=2, data={0xAAAA0001, 0xBBBB0002}, RDY=1, no checksum → beats (0x00050002,3), (0xAAAA0001,2), (0xBBBB0002,1); in$enq__RDY high again 4 cycles after acceptance.
- count=0, method=0x0003 → single beat (0x00030000,1); next message accepted the cycle after the beat transfers.
- RDY low for 3 cycles mid-payload → v and length held constant, then the sequence resumes with no beat lost or duplicated.
- count=7 with MAX_WORDS=4 → overflow=1, header eff=4, exactly 5 beats, overflow stays set.
- nRST pulsed during beat 2 of 3 → ENA=0 immediately, outputs zero, in$enq__RDY=1 after release, the next message is serialized from its header.
- With IND_SER_CHECKSUM_EN, method=1, count=1, data=0x0000FFFF → beats (0x00010001,3), (0x0000FFFF,2), (0x0001FFFE,1).

Source files
------------

// File: rtl/ind_ser_pkg.sv
// ind_ser_pkg: shared types and helpers for the indication serializer.
// Holds the FSM state enum, the length tag width and the header packer.
package ind_ser_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } ser_state_e;

  // Header beat: method id in the upper half, effective word count below.
  function automatic logic [31:0] hdr_pack(
    input logic [15:0] method,
    input logic [15:0] eff
  );
    return {method, eff};
  endfunction

endpackage

// File: rtl/ind_serializer.sv
// ind_serializer: whole-message to 32-bit beat serializer for the portal.
// Optional checksum trailer beat enabled by defining IND_SER_CHECKSUM_EN.
module ind_serializer
  import ind_ser_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int METHOD_W  = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    in_enq__ENA,
  input  logic [METHOD_W-1:0]     in_enq_method,
  input  logic [15:0]             in_enq_count,
  input  logic [32*MAX_WORDS-1:0] in_enq_data,
  output logic                    in_enq__RDY,
  output logic                    out_enq__ENA,
  output logic [31:0]             out_enq_v,
  output logic [15:0]             out_enq_length,
  input  logic                    out_enq__RDY,
  output logic                    overflow
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);
`ifdef IND_SER_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  ser_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      store [MAX_WORDS];
  logic [LEN_W-1:0] eff_q;
  logic             ena_q;
  logic [31:0]      v_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic             accept;
  logic             xfer;
  logic             over_in;
  logic [LEN_W-1:0] eff_in;
  logic [LEN_W-1:0] total_in;
  logic [31:0]      hdr_in;
  logic [31:0]      cur_word;
  logic             more_pay;
  logic [31:0]      trailer;
  logic [31:0]      next_v;

`ifdef IND_SER_CHECKSUM_EN
  logic [31:0]      csum_q;
  logic [31:0]      csum_n;
`endif

  assign in_enq__RDY    = (state == IDLE);
  assign out_enq__ENA   = ena_q;
  assign out_enq_v      = v_q;
  assign out_enq_length = len_q;
  assign overflow       = ovf_q;

  assign accept = in_enq__ENA & in_enq__RDY;
  assign xfer   = ena_q & out_enq__RDY;

  // Clamp the incoming count and derive the header beat.
  always_comb begin
    over_in = in_enq_count > LEN_W'(MAX_WORDS);
    eff_in  = over_in ? LEN_W'(MAX_WORDS) : in_enq_count;
    total_in = eff_in + LEN_W'(1 + TRL);
    hdr_in  = hdr_pack(16'(in_enq_method), eff_in);
  end

  // Select the stored payload word at the current index.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (idx == IDX_W'(i)) cur_word = store[i];
    end
  end

`ifdef IND_SER_CHECKSUM_EN
  assign csum_n  = csum_q ^ v_q;
  assign trailer = csum_n;
`else
  assign trailer = '0;
`endif

  // Next beat after a transfer: payload while words remain, else trailer.
  always_comb begin
    more_pay = LEN_W'(idx) < eff_q;
    next_v   = more_pay ? cur_word : trailer;
  end

  // Payload capture on message acceptance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < MAX_WORDS; i++) store[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < MAX_WORDS; i++)
        store[i] <= in_enq_data[32*i +: 32];
    end
  end

  // Serializer FSM with registered beat outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      idx   <= '0;
      eff_q <= '0;
      ena_q <= 1'b0;
      v_q   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
`ifdef IND_SER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= HDR;
            idx   <= '0;
            eff_q <= eff_in;
            ena_q <= 1'b1;
            v_q   <= hdr_in;
            len_q <= total_in;
            ovf_q <= ovf_q | over_in;
`ifdef IND_SER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        HDR, PAY: begin
          if (xfer) begin
            if (len_q == LEN_W'(1)) begin
              state <= IDLE;
              ena_q <= 1'b0;
              v_q   <= '0;
              len_q <= '0;
              idx   <= '0;
            end else begin
              state <= PAY;
              v_q   <= next_v;
              len_q <= len_q - LEN_W'(1);
              if (more_pay) idx <= idx + IDX_W'(1);
`ifdef IND_SER_CHECKSUM_EN
              csum_q <= csum_n;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          ena_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ind_serializer.sv
// tb_ind_serializer: vector table, corner sequences and random messages
// checked against a message-level beat model.
module tb_ind_serializer;

  localparam int MW = 4;
`ifdef IND_SER_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_ena = 1'b0;
  logic [15:0]   in_method = '0;
  logic [15:0]   in_count = '0;
  logic [127:0]  in_data = '0;
  logic          in_rdy;
  logic          out_ena;
  logic [31:0]   out_v;
  logic [15:0]   out_len;
  logic          out_rdy = 1'b0;
  logic          ovf;

  int n_run = 0;
  int n_fail = 0;
  logic m_ovf = 1'b0;

  always #5 CLK = ~CLK;

  ind_serializer #(.MAX_WORDS(MW), .METHOD_W(16)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .in_enq__ENA(in_ena),
    .in_enq_method(in_method),
    .in_enq_count(in_count),
    .in_enq_data(in_data),
    .in_enq__RDY(in_rdy),
    .out_enq__ENA(out_ena),
    .out_enq_v(out_v),
    .out_enq_length(out_len),
    .out_enq__RDY(out_rdy),
    .overflow(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Send one message and follow all its beats against the model.
  // mode 0: RDY always 1, 1: random RDY, 2: RDY low for cycles 2..4.
  task automatic run_msg(input logic [15:0] m, input logic [15:0] c,
                         input logic [127:0] d, input int mode,
                         output logic [31:0] hv, output logic [15:0] hl,
                         output int ncyc);
    logic [31:0] ev[$];
    logic [15:0] el[$];
    logic [31:0] x;
    logic [31:0] w;
    int eff, total, cyc, head;
    logic r;
    eff = (int'(c) > MW) ? MW : int'(c);
    total = eff + 1 + TRL;
    x = {m, 16'(eff)};
    ev.push_back(x);
    el.push_back(16'(total));
    for (int k = 0; k < eff; k++) begin
      w = d[32*k +: 32];
      ev.push_back(w);
      el.push_back(16'(total - 1 - k));
      x = x ^ w;
    end
    if (TRL != 0) begin
      ev.push_back(x);
      el.push_back(16'd1);
    end
    if (int'(c) > MW) m_ovf = 1'b1;
    cyc = 0;
    while (!in_rdy && cyc < 50) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("in_rdy_wait", {31'd0, in_rdy}, 32'd1);
    in_ena = 1'b1;
    in_method = m;
    in_count = c;
    in_data = d;
    @(posedge CLK); #1;
    in_ena = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_count = 16'($urandom);
    hv = out_v;
    hl = out_len;
    head = 0;
    cyc = 0;
    while (head < ev.size() && cyc < 300) begin
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: r = !(cyc >= 2 && cyc < 5);
      endcase
      out_rdy = r;
      chk("beat_ena", {31'd0, out_ena}, 32'd1);
      chk("busy_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("beat_v", out_v, ev[head]);
      chk("beat_len", {16'd0, out_len}, {16'd0, el[head]});
      if (r) head++;
      @(posedge CLK); #1;
      cyc++;
    end
    if (head < ev.size()) chk("beat_timeout", 32'(head), 32'(ev.size()));
    ncyc = cyc;
    out_rdy = 1'b0;
    chk("done_ena", {31'd0, out_ena}, 32'd0);
    chk("done_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  typedef struct {
    logic [15:0]  method;
    logic [15:0]  count;
    logic [127:0] data;
    logic [31:0]  exp_hdr;
    logic [15:0]  exp_tot;
    logic         exp_ovf;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] hv;
    logic [15:0] hl;
    int nc;

    vt[0] = '{16'h0005, 16'd2, {64'd0, 32'hBBBB0002, 32'hAAAA0001},
              32'h00050002, 16'd3, 1'b0};
    vt[1] = '{16'h0003, 16'd0, 128'd0, 32'h00030000, 16'd1, 1'b0};
    vt[2] = '{16'hFFFF, 16'd4, {32'd4, 32'd3, 32'd2, 32'd1},
              32'hFFFF0004, 16'd5, 1'b0};
    vt[3] = '{16'h1234, 16'd1, {96'd0, 32'hDEADBEEF},
              32'h12340001, 16'd2, 1'b0};
    vt[4] = '{16'h0042, 16'd7, {32'h44, 32'h33, 32'h22, 32'h11},
              32'h00420004, 16'd5, 1'b1};
    vt[5] = '{16'h0009, 16'd3, {32'h0, 32'hC3, 32'hB2, 32'hA1},
              32'h00090003, 16'd4, 1'b1};

    #3;
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst_ena", {31'd0, out_ena}, 32'd0);
    chk("rst_v", out_v, 32'd0);
    chk("rst_len", {16'd0, out_len}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      run_msg(vt[i].method, vt[i].count, vt[i].data, 0, hv, hl, nc);
      chk("tbl_hdr", hv, vt[i].exp_hdr);
      chk("tbl_tot", {16'd0, hl}, {16'd0, vt[i].exp_tot} + 32'(TRL));
      chk("tbl_cycles", 32'(nc + 1),
          {16'd0, vt[i].exp_tot} + 32'(TRL) + 32'd1);
      chk("tbl_ovf", {31'd0, ovf}, {31'd0, vt[i].exp_ovf});
    end

    run_msg(16'h0077, 16'd4, {32'h4444, 32'h3333, 32'h2222, 32'h1111},
            2, hv, hl, nc);
    chk("stall_cycles", 32'(nc), 32'(5 + TRL + 3));

    in_ena = 1'b1;
    in_method = 16'h0007;
    in_count = 16'd2;
    in_data = {64'd0, 32'h0000BEEF, 32'h0000CAFE};
    @(posedge CLK); #1;
    in_ena = 1'b0;
    out_rdy = 1'b1;
    @(posedge CLK); #1;
    chk("mid_beat2_v", out_v, 32'h0000CAFE);
    chk("mid_beat2_len", {16'd0, out_len}, 32'(2 + TRL));
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ena", {31'd0, out_ena}, 32'd0);
    chk("mid_rst_v", out_v, 32'd0);
    chk("mid_rst_len", {16'd0, out_len}, 32'd0);
    chk("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    m_ovf = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    out_rdy = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_ena", {31'd0, out_ena}, 32'd0);
    chk("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    run_msg(16'h000A, 16'd2, {64'd0, 32'h2, 32'h1}, 0, hv, hl, nc);
    chk("post_rst_hdr", hv, 32'h000A0002);

`ifdef IND_SER_CHECKSUM_EN
    run_msg(16'h0001, 16'd1, {96'd0, 32'h0000FFFF}, 0, hv, hl, nc);
    chk("csum_hdr", hv, 32'h00010001);
    chk("csum_tot", {16'd0, hl}, 32'd3);
`endif

    for (int i = 0; i < 40; i++) begin
      run_msg(16'($urandom), 16'($urandom_range(0, 6)),
              {$urandom, $urandom, $urandom, $urandom}, 1, hv, hl, nc);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
